tea_block_engine: RTL and testbench

//  Parametrised successor to the single-mode TEA accelerator: iterative TEA block cipher core that

---
 rtl/tea_block_engine.sv | 173 +++++++++++++++++
 tb/tb_tea_block_engine.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tea_block_engine.sv
// tea_block_engine: iterative TEA block cipher core, encrypt or decrypt per block, UNROLL TEA cycles per clock.
// Latency: block accepted at edge T -> o_axis_valid_m high after edge T+NUM_CYCLES/UNROLL; one block in flight.
// Backpressure: o_axis_ready_s low in RUN/DONE; result and valid held in DONE until i_axis_ready_m.
module tea_block_engine #(
    parameter int          NUM_CYCLES = 32,
    parameter int          UNROLL     = 1,
    parameter logic [31:0] DELTA      = 32'h9E3779B9
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [127:0] i_key,
    input  logic         i_axis_valid_s,
    output logic         o_axis_ready_s,
    input  logic [63:0]  i_axis_data_s,
    input  logic         i_axis_user_s,
    output logic         o_axis_valid_m,
    input  logic         i_axis_ready_m,
    output logic [63:0]  o_axis_data_m,
    output logic         o_busy
);

    // Number of RUN clocks per block and the counter sized to hold that value.
    localparam int STEPS = NUM_CYCLES / UNROLL;
    localparam int CNT_W = $clog2(STEPS + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    // Decryption starts from the sum the encryptor ends with: DELTA*NUM_CYCLES mod 2^32.
    localparam logic [63:0] DEC_SUM_FULL = 64'(DELTA) * 64'(NUM_CYCLES);
    localparam logic [31:0] DEC_SUM      = DEC_SUM_FULL[31:0];

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic [31:0]       v0_q;
    logic [31:0]       v1_q;
    logic [31:0]       sum_q;
    logic [127:0]      key_q;
    logic              mode_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              valid_m_q;
    logic [63:0]       data_m_q;

    // FSM strobes consumed by the datapath register block.
    logic              accept;
    logic              step;
    logic              finish;
    logic              release_out;

    // Output of the UNROLL-deep combinational round chain.
    logic [31:0]       c_v0;
    logic [31:0]       c_v1;
    logic [31:0]       c_sum;

    logic [31:0]       k0;
    logic [31:0]       k1;
    logic [31:0]       k2;
    logic [31:0]       k3;

    assign k0 = key_q[31:0];
    assign k1 = key_q[63:32];
    assign k2 = key_q[95:64];
    assign k3 = key_q[127:96];

    assign o_axis_valid_m = valid_m_q;
    assign o_axis_data_m  = data_m_q;

    // State register; reset returns to IDLE regardless of any block in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and handshake outputs; the output handshake and an input accept never share a cycle.
    always_comb begin
        state_d        = state_q;
        accept         = 1'b0;
        step           = 1'b0;
        finish         = 1'b0;
        release_out    = 1'b0;
        o_axis_ready_s = 1'b0;
        o_busy         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                o_axis_ready_s = 1'b1;
                if (i_axis_valid_s) begin
                    accept  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                o_busy = 1'b1;
                step   = 1'b1;
                if (cnt_q == LAST_STEP) begin
                    finish  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                o_busy = 1'b1;
                if (i_axis_ready_m) begin
                    release_out = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Round chain: UNROLL full TEA cycles per clock, direction chosen by the latched mode bit.
    always_comb begin
        c_v0  = v0_q;
        c_v1  = v1_q;
        c_sum = sum_q;
        for (int i = 0; i < UNROLL; i++) begin
            if (!mode_q) begin
                c_sum = c_sum + DELTA;
                c_v0  = c_v0 + (((c_v1 << 4) + k0) ^ (c_v1 + c_sum) ^ ((c_v1 >> 5) + k1));
                c_v1  = c_v1 + (((c_v0 << 4) + k2) ^ (c_v0 + c_sum) ^ ((c_v0 >> 5) + k3));
            end else begin
                c_v1  = c_v1 - (((c_v0 << 4) + k2) ^ (c_v0 + c_sum) ^ ((c_v0 >> 5) + k3));
                c_v0  = c_v0 - (((c_v1 << 4) + k0) ^ (c_v1 + c_sum) ^ ((c_v1 >> 5) + k1));
                c_sum = c_sum - DELTA;
            end
        end
    end

    // Datapath: latch block/key/mode at accept, iterate in RUN, capture and hold the result until handshake.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            v0_q      <= '0;
            v1_q      <= '0;
            sum_q     <= '0;
            key_q     <= '0;
            mode_q    <= 1'b0;
            cnt_q     <= '0;
            valid_m_q <= 1'b0;
            data_m_q  <= '0;
        end else begin
            if (accept) begin
                v0_q   <= i_axis_data_s[31:0];
                v1_q   <= i_axis_data_s[63:32];
                key_q  <= i_key;
                mode_q <= i_axis_user_s;
                sum_q  <= i_axis_user_s ? DEC_SUM : 32'd0;
                cnt_q  <= '0;
            end else if (step) begin
                v0_q   <= c_v0;
                v1_q   <= c_v1;
                sum_q  <= c_sum;
                cnt_q  <= cnt_q + CNT_W'(1);
            end

            if (finish) begin
                data_m_q  <= {c_v1, c_v0};
                valid_m_q <= 1'b1;
            end else if (release_out) begin
                valid_m_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tea_block_engine.sv
`timescale 1ns/1ps
module tb_tea_block_engine;

    localparam logic [63:0]  VEC1_CT = 64'h94BAA940_41EA3A0A;
    localparam logic [127:0] KEY3    = 128'h0123456789ABCDEF_FEDCBA9876543210;

    logic         clk;
    logic         rst;
    logic [127:0] key;
    logic         valid_s;
    logic         ready_s;
    logic [63:0]  data_s;
    logic         user_s;
    logic         valid_m;
    logic         ready_m;
    logic [63:0]  data_m;
    logic         busy;

    logic         valid_s4, ready_s4, valid_m4, ready_m4, busy4;
    logic [63:0]  data_m4;
    logic         valid_s32, ready_s32, valid_m32, ready_m32, busy32;
    logic [63:0]  data_m32;

    int           n_cmp;
    int           n_err;
    int           cyc;
    int           acc_cyc;
    logic [63:0]  sb_q[$];
    logic [63:0]  exp_m;

    tea_block_engine dut (
        .i_clk(clk), .i_rst(rst), .i_key(key),
        .i_axis_valid_s(valid_s), .o_axis_ready_s(ready_s),
        .i_axis_data_s(data_s), .i_axis_user_s(user_s),
        .o_axis_valid_m(valid_m), .i_axis_ready_m(ready_m),
        .o_axis_data_m(data_m), .o_busy(busy)
    );

    tea_block_engine #(.UNROLL(4)) u_unroll4 (
        .i_clk(clk), .i_rst(rst), .i_key(key),
        .i_axis_valid_s(valid_s4), .o_axis_ready_s(ready_s4),
        .i_axis_data_s(data_s), .i_axis_user_s(user_s),
        .o_axis_valid_m(valid_m4), .i_axis_ready_m(ready_m4),
        .o_axis_data_m(data_m4), .o_busy(busy4)
    );

    tea_block_engine #(.UNROLL(32)) u_unroll32 (
        .i_clk(clk), .i_rst(rst), .i_key(key),
        .i_axis_valid_s(valid_s32), .o_axis_ready_s(ready_s32),
        .i_axis_data_s(data_s), .i_axis_user_s(user_s),
        .o_axis_valid_m(valid_m32), .i_axis_ready_m(ready_m32),
        .o_axis_data_m(data_m32), .o_busy(busy32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference TEA encryption, written from the classic C routine.
    function automatic logic [63:0] ref_enc(input logic [63:0] blk, input logic [127:0] k);
        logic [31:0] y, z, s;
        y = blk[31:0];
        z = blk[63:32];
        s = 32'd0;
        for (int n = 0; n < 32; n++) begin
            s = s + 32'h9E3779B9;
            y = y + (((z << 4) + k[31:0]) ^ (z + s) ^ ((z >> 5) + k[63:32]));
            z = z + (((y << 4) + k[95:64]) ^ (y + s) ^ ((y >> 5) + k[127:96]));
        end
        return {z, y};
    endfunction

    // Scoreboard monitor: each output handshake pops the oldest expected result.
    always @(negedge clk) begin
        if (!rst && valid_m && ready_m) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: got %h, no result expected", data_m);
            end else begin
                exp_m = sb_q.pop_front();
                if (data_m !== exp_m) begin
                    n_err++;
                    $display("FAIL sb_data: got %h, need %h", data_m, exp_m);
                end
            end
        end
    end

    // Offer a block until accepted; on the accept edge push its expected result.
    task automatic send(input logic [63:0] d, input logic u, input logic [127:0] k, input logic [63:0] e);
        int t;
        t = 0;
        key = k; data_s = d; user_s = u; valid_s = 1'b1;
        while (!ready_s && t < 200) begin
            @(posedge clk); #1; t++;
        end
        n_cmp++;
        if (!ready_s) begin
            n_err++;
            $display("FAIL send_timeout: ready_s=%0b after %0d clocks, need 1", ready_s, t);
            valid_s = 1'b0;
        end else begin
            @(posedge clk);
            sb_q.push_back(e);
            #1;
            acc_cyc = cyc;
            valid_s = 1'b0;
        end
    endtask

    // Count clocks from accept until valid_m rises (bounded at 100).
    task automatic wait_valid(output int n);
        n = 0;
        while (!valid_m && n < 100) begin
            @(posedge clk); #1; n++;
        end
    endtask

    // Wait for the scoreboard to empty (bounded).
    task automatic drain(output int left);
        int t;
        t = 0;
        while (sb_q.size() != 0 && t < 200) begin
            @(posedge clk); #1; t++;
        end
        left = sb_q.size();
    endtask

    task automatic test_reset();
        rst = 1'b1; valid_s = 1'b0; ready_m = 1'b0; key = '0; data_s = '0; user_s = 1'b0;
        valid_s4 = 1'b0; valid_s32 = 1'b0; ready_m4 = 1'b0; ready_m32 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        n_cmp++; if (ready_s !== 1'b1) begin n_err++; $display("FAIL reset_ready_s: got %b, need 1", ready_s); end
        n_cmp++; if (valid_m !== 1'b0) begin n_err++; $display("FAIL reset_valid_m: got %b, need 0", valid_m); end
        n_cmp++; if (data_m !== 64'd0) begin n_err++; $display("FAIL reset_data_m: got %h, need 0", data_m); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b, need 0", busy); end
    endtask

    task automatic test_encrypt_vector();
        int n;
        send(64'd0, 1'b0, 128'd0, VEC1_CT);
        key = {$urandom(), $urandom(), $urandom(), $urandom()};
        data_s = {$urandom(), $urandom()};
        user_s = 1'b1;
        n_cmp++;
        if (busy !== 1'b1 || ready_s !== 1'b0) begin
            n_err++; $display("FAIL enc_run_flags: busy=%b ready_s=%b, need busy=1 ready_s=0", busy, ready_s);
        end
        wait_valid(n);
        n_cmp++; if (n !== 32) begin n_err++; $display("FAIL enc_latency: got %0d, need 32", n); end
        n_cmp++; if (data_m !== VEC1_CT) begin n_err++; $display("FAIL enc_vector: got %h, need %h", data_m, VEC1_CT); end
        ready_m = 1'b1;
        @(posedge clk); #1;
        ready_m = 1'b0;
        n_cmp++;
        if (valid_m !== 1'b0 || ready_s !== 1'b1 || busy !== 1'b0) begin
            n_err++; $display("FAIL enc_release: valid_m=%b ready_s=%b busy=%b, need 0 1 0", valid_m, ready_s, busy);
        end
    endtask

    task automatic test_decrypt_vector();
        int n;
        send(VEC1_CT, 1'b1, 128'd0, 64'd0);
        user_s = 1'b0;
        wait_valid(n);
        n_cmp++; if (n !== 32) begin n_err++; $display("FAIL dec_latency: got %0d, need 32", n); end
        n_cmp++; if (data_m !== 64'd0) begin n_err++; $display("FAIL dec_vector: got %h, need 0", data_m); end
        ready_m = 1'b1;
        @(posedge clk); #1;
        ready_m = 1'b0;
    endtask

    task automatic test_random_roundtrip();
        logic [63:0] pt[100];
        logic [63:0] ct[100];
        int left;
        ready_m = 1'b1;
        for (int i = 0; i < 100; i++) begin
            pt[i] = {$urandom(), $urandom()};
            ct[i] = ref_enc(pt[i], KEY3);
            send(pt[i], 1'b0, KEY3, ct[i]);
        end
        for (int i = 0; i < 100; i++) begin
            send(ct[i], 1'b1, KEY3, pt[i]);
        end
        drain(left);
        ready_m = 1'b0;
        n_cmp++; if (left !== 0) begin n_err++; $display("FAIL roundtrip_drain: %0d results outstanding, need 0", left); end
    endtask

    task automatic test_back_to_back();
        int stamps[3];
        int left;
        logic [127:0] k;
        logic [63:0]  p;
        ready_m = 1'b1;
        for (int i = 0; i < 3; i++) begin
            k = {$urandom(), $urandom(), $urandom(), $urandom()};
            p = {$urandom(), $urandom()};
            send(p, 1'b0, k, ref_enc(p, k));
            stamps[i] = acc_cyc;
        end
        drain(left);
        ready_m = 1'b0;
        for (int i = 1; i < 3; i++) begin
            n_cmp++;
            if (stamps[i] - stamps[i-1] !== 34) begin
                n_err++; $display("FAIL b2b_interval: got %0d clocks, need 34", stamps[i] - stamps[i-1]);
            end
        end
        n_cmp++; if (left !== 0) begin n_err++; $display("FAIL b2b_drain: %0d outstanding, need 0", left); end
    endtask

    task automatic test_hold_done();
        int n;
        ready_m = 1'b0;
        send(64'd0, 1'b0, 128'd0, VEC1_CT);
        wait_valid(n);
        n_cmp++; if (n !== 32) begin n_err++; $display("FAIL hold_latency: got %0d, need 32", n); end
        for (int i = 0; i < 10; i++) begin
            key = {$urandom(), $urandom(), $urandom(), $urandom()};
            data_s = {$urandom(), $urandom()};
            user_s = 1'($urandom_range(0, 1));
            valid_s = 1'b1;
            @(posedge clk); #1;
            n_cmp++;
            if (valid_m !== 1'b1 || data_m !== VEC1_CT || ready_s !== 1'b0) begin
                n_err++;
                $display("FAIL hold_cycle%0d: valid_m=%b data=%h ready_s=%b, need 1 %h 0", i, valid_m, data_m, ready_s, VEC1_CT);
            end
        end
        valid_s = 1'b0;
        ready_m = 1'b1;
        @(posedge clk); #1;
        ready_m = 1'b0;
        n_cmp++;
        if (valid_m !== 1'b0 || ready_s !== 1'b1 || busy !== 1'b0) begin
            n_err++; $display("FAIL hold_release: valid_m=%b ready_s=%b busy=%b, need 0 1 0", valid_m, ready_s, busy);
        end
    endtask

    task automatic test_reset_mid_run();
        int n;
        logic seen;
        send(64'd0, 1'b0, 128'd0, VEC1_CT);
        repeat (14) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        void'(sb_q.pop_back());
        n_cmp++;
        if (ready_s !== 1'b1 || valid_m !== 1'b0 || busy !== 1'b0 || data_m !== 64'd0) begin
            n_err++;
            $display("FAIL midrst_state: ready_s=%b valid_m=%b busy=%b data=%h, need 1 0 0 0", ready_s, valid_m, busy, data_m);
        end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (valid_m) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL midrst_no_output: valid_m seen=%b, need 0", seen); end
        ready_m = 1'b1;
        send(64'd0, 1'b0, 128'd0, VEC1_CT);
        wait_valid(n);
        n_cmp++; if (n !== 32) begin n_err++; $display("FAIL midrst_latency: got %0d, need 32", n); end
        @(posedge clk); #1;
        ready_m = 1'b0;
    endtask

    task automatic test_unroll();
        int lat4, lat32;
        logic [63:0] d4, d32;
        key = '0; data_s = '0; user_s = 1'b0;
        ready_m4 = 1'b1; ready_m32 = 1'b1;
        valid_s4 = 1'b1; valid_s32 = 1'b1;
        @(posedge clk); #1;
        valid_s4 = 1'b0; valid_s32 = 1'b0;
        lat4 = -1; lat32 = -1; d4 = '0; d32 = '0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (valid_m4 && lat4 < 0) begin lat4 = n; d4 = data_m4; end
            if (valid_m32 && lat32 < 0) begin lat32 = n; d32 = data_m32; end
        end
        ready_m4 = 1'b0; ready_m32 = 1'b0;
        n_cmp++; if (lat4 !== 8) begin n_err++; $display("FAIL unroll4_latency: got %0d, need 8", lat4); end
        n_cmp++; if (d4 !== VEC1_CT) begin n_err++; $display("FAIL unroll4_data: got %h, need %h", d4, VEC1_CT); end
        n_cmp++; if (lat32 !== 1) begin n_err++; $display("FAIL unroll32_latency: got %0d, need 1", lat32); end
        n_cmp++; if (d32 !== VEC1_CT) begin n_err++; $display("FAIL unroll32_data: got %h, need %h", d32, VEC1_CT); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, need run completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        acc_cyc = 0;
        test_reset();
        test_encrypt_vector();
        test_decrypt_vector();
        test_random_roundtrip();
        test_back_to_back();
        test_hold_done();
        test_reset_mid_run();
        test_unroll();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (sb_q.size() !== 0) begin
            n_err++; $display("FAIL final_scoreboard: %0d outstanding, need 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
